// File: rtl/vmicro16_uart_rx_apb_if.sv
// rtl/vmicro16_uart_rx_apb_if.sv - APB slave bus bundle for the UART receiver
interface vmicro16_uart_rx_apb_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 16
);
  logic [BUS_WIDTH-1:0]  S_PADDR;
  logic                  S_PWRITE;
  logic                  S_PSELx;
  logic                  S_PENABLE;
  logic [DATA_WIDTH-1:0] S_PWDATA;
  logic [DATA_WIDTH-1:0] S_PRDATA;
  logic                  S_PREADY;

  modport master (
    output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    input  S_PRDATA, S_PREADY
  );

  modport slave (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    output S_PRDATA, S_PREADY
  );
endinterface

// File: rtl/vmicro16_uart_rx_apb.sv
// rtl/vmicro16_uart_rx_apb.sv - 8N1 UART receiver with RX FIFO behind an APB slave
module vmicro16_uart_rx_apb #(
  parameter int BUS_WIDTH    = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  vmicro16_uart_rx_apb_if.slave   apb,
  input  logic                    rx_wire
);

  localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = PW + 1;

  localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  // Synchronizer and receiver state
  logic            rx_s1;
  logic            rxs;
  rx_state_t       state;
  logic [BCW-1:0]  bcnt;
  logic [2:0]      bidx;
  logic [7:0]      shreg;

  // FIFO storage and status
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            overrun;
  logic            frame_err;

  // Decoded bus and event strobes
  logic            access;
  logic [1:0]      addr;
  logic            ctrl_wr;
  logic            flush;
  logic            pop;
  logic            full;
  logic            not_empty;
  logic            stop_tick;
  logic            rx_push;
  logic            push_ok;
  logic            overrun_set;
  logic            frame_set;
  logic [3:0]      cnt_field;
  logic [7:0]      status8;
  logic [7:0]      head;
  logic            unused_bits;

  assign access    = apb.S_PSELx & apb.S_PENABLE;
  assign addr      = apb.S_PADDR[1:0];
  assign ctrl_wr   = access & apb.S_PWRITE & (addr == 2'd2);
  assign flush     = ctrl_wr & apb.S_PWDATA[2];
  assign full      = (count == CNT_FULL);
  assign not_empty = (count != '0);
  assign pop       = access & ~apb.S_PWRITE & (addr == 2'd0) & not_empty & ~flush;

  // The stop bit is sampled at its centre; a high stop bit delivers the byte.
  assign stop_tick   = (state == ST_STOP) && (bcnt == BIT_LAST);
  assign rx_push     = stop_tick & rxs;
  assign frame_set   = stop_tick & ~rxs;
  assign push_ok     = rx_push & ~full & ~flush;
  assign overrun_set = rx_push & full & ~flush;

  assign head        = mem[rptr];
  assign unused_bits = ^{apb.S_PADDR, apb.S_PWDATA};

  // Bring the asynchronous line into the clk domain; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rx_wire;
      rxs   <= rx_s1;
    end
  end

  // Deframing FSM: centre-samples start, eight data bits LSB-first, then stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      bcnt  <= '0;
      bidx  <= '0;
      shreg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            bcnt  <= '0;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (bcnt == HALF_LAST) begin
            if (!rxs) begin
              bcnt  <= '0;
              bidx  <= '0;
              state <= ST_DATA;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bcnt == BIT_LAST) begin
            shreg <= {rxs, shreg[7:1]};
            bcnt  <= '0;
            bidx  <= bidx + 1'b1;
            if (bidx == 3'd7) begin
              state <= ST_STOP;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bcnt == BIT_LAST) begin
            bcnt  <= '0;
            state <= ST_IDLE;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; a flush overrides any push or pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write; entries need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= shreg;
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set) begin
        overrun <= 1'b1;
      end else if (ctrl_wr && apb.S_PWDATA[0]) begin
        overrun <= 1'b0;
      end
      if (frame_set) begin
        frame_err <= 1'b1;
      end else if (ctrl_wr && apb.S_PWDATA[1]) begin
        frame_err <= 1'b0;
      end
    end
  end

  // STATUS byte with the occupancy field clamped to four bits.
  always_comb begin
    cnt_field = 4'(count);
    if (32'(count) > 15) begin
      cnt_field = 4'hF;
    end
    status8 = {overrun, frame_err, full, not_empty, cnt_field};
  end

  // Combinational read mux, zero outside a read access phase.
  always_comb begin
    apb.S_PREADY = access;
    apb.S_PRDATA = '0;
    if (access && !apb.S_PWRITE) begin
      case (addr)
        2'd0:    apb.S_PRDATA = not_empty ? DATA_WIDTH'(head) : '0;
        2'd1:    apb.S_PRDATA = DATA_WIDTH'(status8);
        default: apb.S_PRDATA = '0;
      endcase
    end
  end

endmodule
